seg7_reader: RTL and testbench

- Recovers the 4-bit digit code from a 7-bit segment bus driven by the team's segment decoder. Used for loopback checking of display paths and for reading external segment-driven panels.
- Synchronises the asynchronous segment lines and waits for a stable pattern before encoding it.
- Emits one event per new stable pattern on a valid/ready output, and flags blank and unknown patterns.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_pattern_enc.sv | 24 ++
 rtl/seg7_reader.sv | 125 ++++++++++++
 tb/tb_seg7_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment table and event record. The segment decoder and the
// reader both draw on these constants so the two directions cannot drift.
package seg7_pkg;

    localparam int SEG_W  = 7;
    localparam int CODE_W = 4;

    localparam logic [SEG_W-1:0] SEG_D0    = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_D1    = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_D2    = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_D3    = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_D4    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_D5    = 7'b1110001;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic [CODE_W-1:0] data;
        logic              blank;
        logic              err;
    } seg7_evt_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_enc.sv
// Combinational map from a segment pattern to its event record.
// Blank and unknown patterns carry data 0 with the matching flag set.
module seg7_pattern_enc
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output seg7_evt_t        evt
);

    always_comb begin
        evt = '0;
        case (pattern)
            SEG_D0:    evt.data = 4'd0;
            SEG_D1:    evt.data = 4'd1;
            SEG_D2:    evt.data = 4'd2;
            SEG_D3:    evt.data = 4'd3;
            SEG_D4:    evt.data = 4'd4;
            SEG_D5:    evt.data = 4'd5;
            SEG_BLANK: evt.blank = 1'b1;
            default:   evt.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Reads a 7-segment bus back into a digit code: synchronise, debounce,
// encode, and hand each new stable pattern over a valid/ready output.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  seg,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_data,
    output logic              out_blank,
    output logic              out_err,
    output logic              overrun
);

    // Handshake: an event is transferred on a rising edge where out_valid=1
    // and out_ready=1; out_data/out_blank/out_err stay constant while
    // out_valid=1 and out_ready=0.

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] s1;
    logic [SEG_W-1:0] s2;
    logic [SEG_W-1:0] s2_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             changed;
    logic             reach;
    logic             fresh;
    logic             evt_now;

    logic [SEG_W-1:0] last_pat;
    logic             last_vld;
    seg7_state_e      state;
    seg7_evt_t        enc_evt;

    seg7_pattern_enc u_enc (
        .pattern (s2),
        .evt     (enc_evt)
    );

    // cnt counts cycles s2 has repeated beyond its first cycle, so the
    // pattern has been held STABLE_CYCLES cycles exactly when cnt_next hits
    // STABLE_CYCLES-1; saturating above that keeps a held pattern from
    // re-triggering.
    assign changed = (s2 != s2_prev);

    always_comb begin
        cnt_next = cnt;
        if (changed) begin
            cnt_next = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + 1'b1;
        end
    end

    assign reach   = (cnt_next == CNT_HIT);
    assign fresh   = !last_vld || (s2 != last_pat);
    assign evt_now = reach && fresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            s2_prev <= '0;
            cnt     <= '0;
        end else begin
            s1      <= seg;
            s2      <= s1;
            s2_prev <= s2;
            cnt     <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
            last_vld  <= 1'b0;
            last_pat  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (evt_now) begin
                        out_valid <= 1'b1;
                        out_data  <= enc_evt.data;
                        out_blank <= enc_evt.blank;
                        out_err   <= enc_evt.err;
                        last_vld  <= 1'b1;
                        last_pat  <= s2;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (evt_now) begin
                            out_data  <= enc_evt.data;
                            out_blank <= enc_evt.blank;
                            out_err   <= enc_evt.err;
                            last_vld  <= 1'b1;
                            last_pat  <= s2;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_EMPTY;
                        end
                    end else if (evt_now) begin
                        // Dropped events leave last_pat alone and are not retried.
                        overrun <= 1'b1;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Randomised and directed bench for seg7_reader against a run-length
// reference model with an expected-event queue.
module tb_seg7_reader;
    import seg7_pkg::*;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_blank;
    logic       out_err;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;
    int accepted    = 0;

    logic [5:0] exp_q[$];

    logic [6:0] hist[$];
    logic       m_valid;
    logic       m_ovr;
    logic       m_last_vld;
    logic [6:0] m_last;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seg7_reader #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_blank (out_blank),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    // ---------------- reference model ----------------
    function automatic logic [5:0] expect_of(input logic [6:0] p);
        logic [6:0] tab [0:5];
        tab[0] = 7'b1110111;
        tab[1] = 7'b1111100;
        tab[2] = 7'b0111001;
        tab[3] = 7'b1011110;
        tab[4] = 7'b1111001;
        tab[5] = 7'b1110001;
        for (int i = 0; i < 6; i++) begin
            if (p == tab[i]) return {4'(i), 2'b00};
        end
        if (p == 7'd0) return {4'd0, 2'b10};
        return {4'd0, 2'b01};
    endfunction

    // The reader sees, at edge n, the raw sample taken at edge n-2. An event
    // fires on the edge where that sample's run of identical samples first
    // reaches STABLE and it differs from the last reported pattern.
    logic [6:0] m_pat;
    int         m_k;
    int         m_run;
    bit         m_ev;
    bit         m_acc;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            hist.push_back(7'd0);
            hist.push_back(7'd0);
            m_valid    = 1'b0;
            m_ovr      = 1'b0;
            m_last_vld = 1'b0;
            m_last     = 7'd0;
            exp_q.delete();
        end else begin
            hist.push_back(seg);
            if (hist.size() > 32) void'(hist.pop_front());
            m_k   = hist.size() - 3;
            m_pat = hist[m_k];
            m_run = 0;
            while (m_k >= 0 && m_run <= STABLE && hist[m_k] == m_pat) begin
                m_run++;
                m_k--;
            end
            m_ev  = (m_run == STABLE) && (!m_last_vld || m_pat != m_last);
            m_acc = m_valid && out_ready;
            if (m_ev && (!m_valid || m_acc)) begin
                exp_q.push_back(expect_of(m_pat));
                m_last     = m_pat;
                m_last_vld = 1'b1;
                m_valid    = 1'b1;
            end else if (m_ev) begin
                m_ovr = 1'b1;
            end else if (m_acc) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [5:0] mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(1), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_record", 32'({out_data, out_blank, out_err}), 32'(mon_e));
                    accepted++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // rmode: 0 = ready low, 1 = ready high, 2 = random per cycle
    task automatic drive(input logic [6:0] p, input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            seg = p;
            out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_data"}, 32'(out_data), 32'(0));
        check({tag, "_blank"}, 32'(out_blank), 32'(0));
        check({tag, "_err"}, 32'(out_err), 32'(0));
        check({tag, "_overrun"}, 32'(overrun), 32'(0));
    endtask

    task automatic do_reset(input logic [6:0] p, input string tag);
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        seg = p;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int         a0;
    logic [6:0] rp;
    logic [6:0] pool [0:6];

    initial begin
        pool[0] = SEG_D0; pool[1] = SEG_D1; pool[2] = SEG_D2; pool[3] = SEG_D3;
        pool[4] = SEG_D4; pool[5] = SEG_D5; pool[6] = SEG_BLANK;

        rst_n = 1'b0;
        seg = SEG_D0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        a0 = accepted;
        drive(SEG_D0, 12, 1);
        check("first_event_count", 32'(accepted - a0), 32'(1));

        a0 = accepted;
        drive(SEG_D1, 10, 1);
        drive(SEG_D2, 10, 1);
        drive(SEG_D3, 10, 1);
        drive(SEG_D4, 10, 1);
        drive(SEG_D5, 10, 1);
        check("step_event_count", 32'(accepted - a0), 32'(5));

        a0 = accepted;
        drive(7'b0000000, 10, 1);
        drive(7'b1010101, 10, 1);
        check("blank_err_count", 32'(accepted - a0), 32'(2));

        a0 = accepted;
        drive(SEG_D1, 10, 1);
        drive(SEG_D2, 2, 1);
        drive(SEG_D1, 10, 1);
        check("glitch_event_count", 32'(accepted - a0), 32'(1));

        a0 = accepted;
        drive(SEG_D2, 10, 0);
        drive(SEG_D3, 10, 0);
        check("held_valid", 32'(out_valid), 32'(1));
        check("held_data", 32'(out_data), 32'(2));
        check("held_overrun", 32'(overrun), 32'(1));
        drive(SEG_D3, 10, 1);
        check("overrun_event_count", 32'(accepted - a0), 32'(1));
        check("drained_valid", 32'(out_valid), 32'(0));

        drive(SEG_D4, 3, 1);
        do_reset(SEG_D4, "mid_window");
        a0 = accepted;
        drive(SEG_D4, 12, 1);
        check("post_reset_count", 32'(accepted - a0), 32'(1));

        drive(SEG_D5, 10, 0);
        check("pre_reset_valid", 32'(out_valid), 32'(1));
        do_reset(SEG_D5, "mid_handshake");
        a0 = accepted;
        drive(SEG_D5, 12, 1);
        check("post_reset2_count", 32'(accepted - a0), 32'(1));

        rp = SEG_D5;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 8))
                7:       rp = 7'($urandom_range(0, 127));
                8:       rp = rp;
                default: rp = pool[$urandom_range(0, 6)];
            endcase
            drive(rp, $urandom_range(1, 9), 2);
        end
        drive(rp, 12, 1);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
